// File: rtl/mac_tx_frame_arbiter.sv
// mac_tx_frame_arbiter: moves whole frames from two FWFT ingress FIFOs onto
// one TX MAC byte stream. One frame is sent at a time, with no byte
// interleave, followed by a programmable idle gap. Frames longer than
// MAX_FRAME are truncated, and their tail is drained from the FIFO.
// Optional macro ARB_STRICT_PRIO_EN: port 0 always wins arbitration
// (default build: round-robin between the two ports).
module mac_tx_frame_arbiter #(
  parameter int unsigned IFG_CYCLES = 12,
  parameter int unsigned MAX_FRAME  = 1518
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_frame_rdy,
  input  logic        p0_empty,
  input  logic [7:0]  p0_data,
  input  logic        p0_last,
  output logic        p0_rd,
  input  logic        p1_frame_rdy,
  input  logic        p1_empty,
  input  logic [7:0]  p1_data,
  input  logic        p1_last,
  output logic        p1_rd,
  output logic [7:0]  tx_mac_data,
  output logic        tx_mac_valid,
  output logic        tx_mac_last,
  input  logic        tx_mac_ready,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        trunc_pulse,
  output logic [15:0] frame_cnt
);

  localparam int unsigned CNT_W = 11;
  localparam int unsigned IFG_W = 8;
  localparam int unsigned FCW   = 16;

  typedef enum logic [1:0] {IDLE, XFER, DRAIN, IFG} state_t;

  state_t           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             last_grant_q, last_grant_d;  // 0 = port 0, 1 = port 1
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [IFG_W-1:0] ifg_cnt_q, ifg_cnt_d;
  logic [FCW-1:0]   frame_cnt_q, frame_cnt_d;

  logic             sel;
  logic             g_empty;
  logic             g_last;
  logic [7:0]       g_data;
  logic             at_max;
  logic             accept;
  logic             pick_p1;

  // Mux the granted port's FIFO head
  always_comb begin
    sel     = grant_q[1];
    g_empty = sel ? p1_empty : p0_empty;
    g_last  = sel ? p1_last  : p0_last;
    g_data  = sel ? p1_data  : p0_data;
    at_max  = (byte_cnt_q == CNT_W'(MAX_FRAME - 1));
  end

  // Arbitration choice, only consumed in IDLE
  always_comb begin
`ifdef ARB_STRICT_PRIO_EN
    pick_p1 = !p0_frame_rdy;
`else
    pick_p1 = p1_frame_rdy && (!p0_frame_rdy || !last_grant_q);
`endif
  end

  // State and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= 2'b00;
      last_grant_q <= 1'b1;
      byte_cnt_q   <= '0;
      ifg_cnt_q    <= '0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      byte_cnt_q   <= byte_cnt_d;
      ifg_cnt_q    <= ifg_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  // Next-state logic and FIFO-head-driven TX outputs
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    byte_cnt_d   = byte_cnt_q;
    ifg_cnt_d    = ifg_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    tx_mac_data  = 8'h00;
    tx_mac_valid = 1'b0;
    tx_mac_last  = 1'b0;
    p0_rd        = 1'b0;
    p1_rd        = 1'b0;
    trunc_pulse  = 1'b0;
    accept       = 1'b0;

    case (state_q)
      IDLE: begin
        if (p0_frame_rdy || p1_frame_rdy) begin
          grant_d    = pick_p1 ? 2'b10 : 2'b01;
          byte_cnt_d = '0;
          state_d    = XFER;
        end
      end

      XFER: begin
        tx_mac_data  = g_data;
        tx_mac_valid = !g_empty;
        tx_mac_last  = g_last || at_max;
        accept       = tx_mac_valid && tx_mac_ready;
        p0_rd        = accept && !sel;
        p1_rd        = accept && sel;
        if (accept) begin
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
          if (g_last) begin
            frame_cnt_d  = frame_cnt_q + FCW'(1);
            last_grant_d = sel;
            ifg_cnt_d    = IFG_W'(IFG_CYCLES - 1);
            state_d      = IFG;
          end else if (at_max) begin
            trunc_pulse = 1'b1;
            frame_cnt_d = frame_cnt_q + FCW'(1);
            state_d     = DRAIN;
          end
        end
      end

      // Discard the oversize tail up to and including its last byte
      DRAIN: begin
        p0_rd = !g_empty && !sel;
        p1_rd = !g_empty && sel;
        if (!g_empty && g_last) begin
          last_grant_d = sel;
          ifg_cnt_d    = IFG_W'(IFG_CYCLES - 1);
          state_d      = IFG;
        end
      end

      IFG: begin
        if (ifg_cnt_q == '0) begin
          grant_d = 2'b00;
          state_d = IDLE;
        end else begin
          ifg_cnt_d = ifg_cnt_q - IFG_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  assign grant     = grant_q;
  assign busy      = (state_q != IDLE);
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_mac_tx_frame_arbiter.sv
// Self-checking bench for mac_tx_frame_arbiter: queue-based FIFO models,
// a frame-level scoreboard of the expected TX byte stream and gap timing.
module tb_mac_tx_frame_arbiter;

  localparam int unsigned IFG  = 12;
  localparam int unsigned MAXF = 1518;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_frame_rdy, p0_empty, p0_last, p0_rd;
  logic [7:0]  p0_data;
  logic        p1_frame_rdy, p1_empty, p1_last, p1_rd;
  logic [7:0]  p1_data;
  logic [7:0]  tx_mac_data;
  logic        tx_mac_valid, tx_mac_last, tx_mac_ready;
  logic [1:0]  grant;
  logic        busy, trunc_pulse;
  logic [15:0] frame_cnt;

  mac_tx_frame_arbiter #(.IFG_CYCLES(IFG), .MAX_FRAME(MAXF)) dut (
    .clk(clk), .reset(reset),
    .p0_frame_rdy(p0_frame_rdy), .p0_empty(p0_empty), .p0_data(p0_data),
    .p0_last(p0_last), .p0_rd(p0_rd),
    .p1_frame_rdy(p1_frame_rdy), .p1_empty(p1_empty), .p1_data(p1_data),
    .p1_last(p1_last), .p1_rd(p1_rd),
    .tx_mac_data(tx_mac_data), .tx_mac_valid(tx_mac_valid),
    .tx_mac_last(tx_mac_last), .tx_mac_ready(tx_mac_ready),
    .grant(grant), .busy(busy), .trunc_pulse(trunc_pulse),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // FIFO models: byte and last-flag per entry, plus complete-frame counts
  logic [7:0] qd0[$], qd1[$];
  bit         ql0[$], ql1[$];
  int         nfr0 = 0, nfr1 = 0;

  // Expected TX stream (scoreboard) and model state
  logic [7:0] exp_data[$];
  bit         exp_last[$];
  int         exp_port[$];
  int         m_last = 1;
  int         m_frames = 0;
  int         exp_trunc = 0;

  bit force_empty0 = 1'b0;

  // Results of the latest run
  int r_first, r_lastcyc, r_bytes, r_trunc, r_low0;

  task automatic push_frame(input int p, input int len);
    for (int i = 0; i < len; i++) begin
      if (p == 0) begin
        qd0.push_back(8'($urandom)); ql0.push_back(i == len - 1);
      end else begin
        qd1.push_back(8'($urandom)); ql1.push_back(i == len - 1);
      end
    end
    if (p == 0) nfr0++; else nfr1++;
  endtask

  // Arbitration order and truncation from the preloaded FIFO contents
  task automatic build_expected();
    logic [7:0] c0[$], c1[$];
    bit l0[$], l1[$];
    int f0, f1, pick, n;
    bit l;
    logic [7:0] b;
    c0 = qd0; c1 = qd1; l0 = ql0; l1 = ql1; f0 = nfr0; f1 = nfr1;
    while (f0 + f1 > 0) begin
      if (f0 > 0 && f1 > 0) begin
`ifdef ARB_STRICT_PRIO_EN
        pick = 0;
`else
        pick = (m_last == 0) ? 1 : 0;
`endif
      end else begin
        pick = (f0 > 0) ? 0 : 1;
      end
      n = 0;
      do begin
        if (pick == 0) begin b = c0.pop_front(); l = l0.pop_front(); end
        else           begin b = c1.pop_front(); l = l1.pop_front(); end
        if (n < int'(MAXF)) begin
          exp_data.push_back(b);
          exp_last.push_back(l || (n == int'(MAXF) - 1));
          exp_port.push_back(pick);
          if (n == int'(MAXF) - 1 && !l) exp_trunc++;
        end
        n++;
      end while (!l);
      m_last = pick;
      m_frames++;
      if (pick == 0) f0--; else f1--;
    end
  endtask

  task automatic drive_inputs();
    p0_empty     = (qd0.size() == 0) || force_empty0;
    p0_data      = (qd0.size() != 0) ? qd0[0] : 8'h00;
    p0_last      = (ql0.size() != 0) ? ql0[0] : 1'b0;
    p0_frame_rdy = (nfr0 > 0);
    p1_empty     = (qd1.size() == 0);
    p1_data      = (qd1.size() != 0) ? qd1[0] : 8'h00;
    p1_last      = (ql1.size() != 0) ? ql1[0] : 1'b0;
    p1_frame_rdy = (nfr1 > 0);
  endtask

  // mode: 0 ready always, 1 ready toggles, 2 random ready
  // abort_at > 0 stops once that many bytes were accepted
  // uf_at > 0 forces p0 empty for 5 cycles after that many bytes
  task automatic run(input int mode, input int abort_at, input int uf_at);
    int cyc, uf_left, gap_cnt;
    bit gap_on, done, acc, hl, end_evt;
    logic [1:0] eg;
    uf_left = 0; gap_on = 0; gap_cnt = 0; done = 0;
    r_first = -1; r_lastcyc = -1; r_bytes = 0; r_trunc = 0; r_low0 = 0;
    for (cyc = 0; cyc < 20000 && !done; cyc++) begin
      @(negedge clk);
      force_empty0 = (uf_left > 0);
      drive_inputs();
      tx_mac_ready = (mode == 0) ? 1'b1 :
                     (mode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
      #1;
      acc = tx_mac_valid && tx_mac_ready;
      end_evt = 1'b0;
      checks++;
      if ((p0_rd && grant !== 2'b01) || (p1_rd && grant !== 2'b10)) begin
        failures++;
        $display("FAIL rd_owner cyc=%0d p0_rd=%b p1_rd=%b grant=%b", cyc, p0_rd, p1_rd, grant);
      end
      if (tx_mac_valid) begin
        checks++;
        if ((p0_rd | p1_rd) !== tx_mac_ready) begin
          failures++;
          $display("FAIL rd_ready cyc=%0d rd=%b ready=%b", cyc, p0_rd | p1_rd, tx_mac_ready);
        end
        if (r_first < 0) r_first = cyc;
      end
      if (force_empty0) begin
        uf_left--;
        checks++;
        if (tx_mac_valid !== 1'b0) begin
          failures++;
          $display("FAIL underrun_valid cyc=%0d valid=%b expected 0", cyc, tx_mac_valid);
        end else r_low0++;
      end
      if (trunc_pulse) r_trunc++;
      if (acc) begin
        checks++;
        if (exp_data.size() == 0) begin
          failures++;
          $display("FAIL extra_byte cyc=%0d data=%h", cyc, tx_mac_data);
        end else begin
          eg = (exp_port[0] == 0) ? 2'b01 : 2'b10;
          if (tx_mac_data !== exp_data[0] || tx_mac_last !== exp_last[0] || grant !== eg) begin
            failures++;
            $display("FAIL tx_byte cyc=%0d got data=%h last=%b grant=%b expected data=%h last=%b grant=%b",
                     cyc, tx_mac_data, tx_mac_last, grant, exp_data[0], exp_last[0], eg);
          end
          if (exp_last[0]) r_lastcyc = cyc;
          void'(exp_data.pop_front()); void'(exp_last.pop_front()); void'(exp_port.pop_front());
        end
        r_bytes++;
        if (uf_at > 0 && r_bytes == uf_at) uf_left = 5;
      end
      // Model FIFO pops
      if (p0_rd) begin
        if (qd0.size() == 0) begin
          failures++; $display("FAIL rd_empty port0 cyc=%0d", cyc);
        end else begin
          void'(qd0.pop_front()); hl = ql0.pop_front();
          if (hl) begin nfr0--; end_evt = 1'b1; end
        end
      end
      if (p1_rd) begin
        if (qd1.size() == 0) begin
          failures++; $display("FAIL rd_empty port1 cyc=%0d", cyc);
        end else begin
          void'(qd1.pop_front()); hl = ql1.pop_front();
          if (hl) begin nfr1--; end_evt = 1'b1; end
        end
      end
      // Idle gap: exactly IFG busy cycles after a frame's final pop
      if (end_evt) begin
        gap_on = 1'b1; gap_cnt = 0;
      end else if (gap_on) begin
        if (busy) gap_cnt++;
        else begin
          gap_on = 1'b0;
          checks++;
          if (gap_cnt != int'(IFG)) begin
            failures++;
            $display("FAIL ifg_gap cyc=%0d got=%0d expected=%0d", cyc, gap_cnt, IFG);
          end
        end
      end
      if (abort_at > 0 && r_bytes == abort_at) return;
      if (exp_data.size() == 0 && !busy && !gap_on) done = 1'b1;
    end
    if (!done) begin
      failures++;
      $display("FAIL run_timeout remaining_bytes=%0d busy=%b", exp_data.size(), busy);
    end
  endtask

  task automatic check_frame_cnt(input string name);
    checks++;
    if (frame_cnt !== 16'(m_frames)) begin
      failures++;
      $display("FAIL %s frame_cnt got=%0d expected=%0d", name, frame_cnt, m_frames);
    end
  endtask

  task automatic check_trunc(input string name);
    checks++;
    if (r_trunc != exp_trunc) begin
      failures++;
      $display("FAIL %s trunc_pulses got=%0d expected=%0d", name, r_trunc, exp_trunc);
    end
    exp_trunc = 0;
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if (tx_mac_valid !== 1'b0 || tx_mac_last !== 1'b0 || tx_mac_data !== 8'h00 ||
        p0_rd !== 1'b0 || p1_rd !== 1'b0 || grant !== 2'b00 || busy !== 1'b0 ||
        trunc_pulse !== 1'b0 || frame_cnt !== 16'h0000) begin
      failures++;
      $display("FAIL %s outputs valid=%b last=%b data=%h rd=%b%b grant=%b busy=%b trunc=%b fcnt=%0d expected all 0",
               name, tx_mac_valid, tx_mac_last, tx_mac_data, p1_rd, p0_rd, grant, busy,
               trunc_pulse, frame_cnt);
    end
  endtask

  task automatic clear_model();
    qd0.delete(); qd1.delete(); ql0.delete(); ql1.delete();
    exp_data.delete(); exp_last.delete(); exp_port.delete();
    nfr0 = 0; nfr1 = 0; m_last = 1; m_frames = 0; exp_trunc = 0; force_empty0 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tx_mac_ready = 1'b1;
    drive_inputs();
    repeat (3) @(negedge clk);
    #1 check_outputs_zero("reset");
    @(negedge clk) reset = 1'b1;
    #1 check_outputs_zero("after_release");
  endtask

  task automatic test_single_frame();
    push_frame(0, 64);
    build_expected();
    run(0, 0, 0);
    checks++;
    if (r_first != 1) begin
      failures++; $display("FAIL first_valid_latency got=%0d expected=1", r_first);
    end
    checks++;
    if (r_lastcyc - r_first != 63 || r_bytes != 64) begin
      failures++;
      $display("FAIL single_contiguous span=%0d bytes=%0d expected 63/64", r_lastcyc - r_first, r_bytes);
    end
    check_frame_cnt("single");
    check_trunc("single");
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 3; i++) begin
      push_frame(0, 100);
      push_frame(1, 100);
    end
    build_expected();
    run(0, 0, 0);
    checks++;
    if (r_bytes != 600) begin
      failures++; $display("FAIL rr_bytes got=%0d expected=600", r_bytes);
    end
    check_frame_cnt("round_robin");
    check_trunc("round_robin");
  endtask

  task automatic test_ready_toggle();
    push_frame(1, 70);
    build_expected();
    run(1, 0, 0);
    checks++;
    if (r_bytes != 70) begin
      failures++; $display("FAIL toggle_bytes got=%0d expected=70", r_bytes);
    end
    check_frame_cnt("ready_toggle");
  endtask

  task automatic test_truncate();
    push_frame(0, 1600);
    push_frame(1, 64);
    build_expected();
    run(0, 0, 0);
    check_trunc("truncate");
    checks++;
    if (qd0.size() != 0 || qd1.size() != 0 || r_bytes != int'(MAXF) + 64) begin
      failures++;
      $display("FAIL truncate_drain left0=%0d left1=%0d bytes=%0d expected 0/0/%0d",
               qd0.size(), qd1.size(), r_bytes, MAXF + 64);
    end
    check_frame_cnt("truncate");
  endtask

  task automatic test_exact_max();
    push_frame(1, int'(MAXF));
    build_expected();
    run(0, 0, 0);
    check_trunc("exact_max");
    check_frame_cnt("exact_max");
  endtask

  task automatic test_underrun();
    push_frame(0, 64);
    build_expected();
    run(0, 0, 10);
    checks++;
    if (r_bytes != 64 || r_low0 != 5) begin
      failures++;
      $display("FAIL underrun bytes=%0d low_cycles=%0d expected 64/5", r_bytes, r_low0);
    end
    check_frame_cnt("underrun");
  endtask

  task automatic test_random();
    int n0, n1, len;
    for (int it = 0; it < 3; it++) begin
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range(1, 3);
      for (int i = 0; i < n0 + n1; i++) begin
        len = ($urandom_range(0, 9) == 0) ? $urandom_range(int'(MAXF) + 1, int'(MAXF) + 20)
                                          : $urandom_range(64, 200);
        push_frame((i < n0) ? 0 : 1, len);
      end
      build_expected();
      run(2, 0, 0);
      check_trunc("random");
      check_frame_cnt("random");
    end
  endtask

  task automatic test_reset_midframe();
    push_frame(0, 64);
    push_frame(1, 64);
    build_expected();
    run(0, 30, 0);
    reset = 1'b0;
    #1 check_outputs_zero("reset_midframe");
    clear_model();
    drive_inputs();
    @(negedge clk);
    @(negedge clk) reset = 1'b1;
    push_frame(0, 64);
    push_frame(1, 64);
    build_expected();
    run(0, 0, 0);
    check_frame_cnt("post_reset");
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_ready_toggle();
    test_truncate();
    test_exact_max();
    test_underrun();
    test_random();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
